// File: rtl/iob_timer_mc_if.sv
// Native slave bus bundle for iob_timer_mc: one request strobe, registered one-cycle acknowledge.
interface iob_timer_mc_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  // Handshake: every cycle with valid=1 is one request (nonzero wstrb = write, zero = read);
  // ready pulses exactly one cycle later with rdata; there is no back-pressure.
  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_timer_mc.sv
// Multi-channel prescaled timer with N_CH compare channels, sticky flags and per-channel irq.
// Define TIMER_MC_PERIODIC_EN to build the periodic mode and PERIOD registers.
module iob_timer_mc #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 64,
  parameter int N_CH    = 4,
  parameter int PRESC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  iob_timer_mc_if.slave   bus,
  output logic [N_CH-1:0] irq
);
  localparam int IDX_W = ADDR_W - 2;

  logic               ctrl_en_q;
  logic [PRESC_W-1:0] presc_q, pcnt_q;
  logic [CNT_W-1:0]   cnt_q, cnt_reg_q, cnt_inc;
  logic [DATA_W-1:0]  shadow_q [N_CH];
  logic [CNT_W-1:0]   cmp_q [N_CH];
  logic [N_CH-1:0]    ch_en_q, irq_en_q, flag_q, irq_q, match;
`ifdef TIMER_MC_PERIODIC_EN
  logic [DATA_W-1:0]  period_q [N_CH];
  logic [N_CH-1:0]    periodic_q;
`endif
  logic               ready_q;
  logic [DATA_W-1:0]  rdata_q, rd_mux;

  logic               wr_en, rd_en, glob_sel, soft_rst, sample, tick;
  logic [ADDR_W-1:0]  ch_off;
  logic [IDX_W-1:0]   ch_idx;
  logic [1:0]         ch_reg;
  logic [N_CH-1:0]    ch_hit;

  function automatic logic [DATA_W-1:0] hi_word(input logic [CNT_W-1:0] v);
    logic [2*DATA_W-1:0] ext;
    ext = (2*DATA_W)'(v);
    return ext[2*DATA_W-1:DATA_W];
  endfunction

  assign wr_en    = bus.valid & (|bus.wstrb);
  assign rd_en    = bus.valid & ~(|bus.wstrb);
  assign glob_sel = bus.address < ADDR_W'(8);
  assign ch_off   = bus.address - ADDR_W'(8);
  assign ch_idx   = ch_off[ADDR_W-1:2];
  assign ch_reg   = ch_off[1:0];
  assign soft_rst = wr_en & glob_sel & (bus.address[2:0] == 3'd0) & bus.wdata[1];
  assign sample   = wr_en & glob_sel & (bus.address[2:0] == 3'd0) & bus.wdata[2];
  // A soft reset swallows the tick of its own cycle so no match fires off a counter being cleared.
  assign tick     = ctrl_en_q & (pcnt_q == presc_q) & ~soft_rst;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    ch_hit = '0;
    match  = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_hit[c] = ~glob_sel & (ch_idx == IDX_W'(c));
      match[c]  = tick & ch_en_q[c] & (cnt_inc == cmp_q[c]);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (glob_sel) begin
      case (bus.address[2:0])
        3'd0:    rd_mux[0] = ctrl_en_q;
        3'd1:    rd_mux = DATA_W'(presc_q);
        3'd2:    rd_mux = cnt_reg_q[DATA_W-1:0];
        3'd3:    rd_mux = hi_word(cnt_reg_q);
        3'd4:    rd_mux = DATA_W'(flag_q);
        default: rd_mux = '0;
      endcase
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_hit[c]) begin
          case (ch_reg)
            2'd0: rd_mux = cmp_q[c][DATA_W-1:0];
            2'd1: rd_mux = hi_word(cmp_q[c]);
`ifdef TIMER_MC_PERIODIC_EN
            2'd2: rd_mux = period_q[c];
`else
            2'd2: rd_mux = '0;
`endif
            default: begin
              rd_mux[0] = ch_en_q[c];
`ifdef TIMER_MC_PERIODIC_EN
              rd_mux[1] = periodic_q[c];
`endif
              rd_mux[2] = irq_en_q[c];
              rd_mux[8] = flag_q[c];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en_q <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      cnt_reg_q <= '0;
      ch_en_q   <= '0;
      irq_en_q  <= '0;
      flag_q    <= '0;
      irq_q     <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        shadow_q[c] <= '0;
        cmp_q[c]    <= '0;
`ifdef TIMER_MC_PERIODIC_EN
        period_q[c] <= '0;
`endif
      end
`ifdef TIMER_MC_PERIODIC_EN
      periodic_q <= '0;
`endif
    end else begin
      ready_q <= bus.valid;
      rdata_q <= rd_en ? rd_mux : '0;
      irq_q   <= flag_q & irq_en_q;

      if (soft_rst) begin
        pcnt_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (ctrl_en_q) pcnt_q <= (pcnt_q == presc_q) ? '0 : pcnt_q + PRESC_W'(1);
        if (tick) cnt_q <= cnt_inc;
      end
      if (sample) cnt_reg_q <= cnt_q;

      if (wr_en && glob_sel && bus.address[2:0] == 3'd0) ctrl_en_q <= bus.wdata[0];
      if (wr_en && glob_sel && bus.address[2:0] == 3'd1) presc_q <= bus.wdata[PRESC_W-1:0];

      // Match updates come first so a same-cycle bus write to cmp/ch_en overrides them.
      for (int c = 0; c < N_CH; c++) begin
        if (match[c]) begin
          flag_q[c] <= 1'b1;
`ifdef TIMER_MC_PERIODIC_EN
          if (periodic_q[c]) cmp_q[c] <= cmp_q[c] + CNT_W'(period_q[c]);
          else               ch_en_q[c] <= 1'b0;
`else
          ch_en_q[c] <= 1'b0;
`endif
        end else if (wr_en && ch_hit[c] && ch_reg == 2'd3 && bus.wdata[8]) begin
          flag_q[c] <= 1'b0;
        end

        if (wr_en && ch_hit[c]) begin
          case (ch_reg)
            2'd0: shadow_q[c] <= bus.wdata;
            2'd1: cmp_q[c]    <= CNT_W'({bus.wdata, shadow_q[c]});
`ifdef TIMER_MC_PERIODIC_EN
            2'd2: period_q[c] <= bus.wdata;
`else
            2'd2: ;
`endif
            default: begin
              ch_en_q[c]  <= bus.wdata[0];
`ifdef TIMER_MC_PERIODIC_EN
              periodic_q[c] <= bus.wdata[1];
`endif
              irq_en_q[c] <= bus.wdata[2];
            end
          endcase
        end
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;
endmodule

// File: doc/iob_timer_mc.md
# iob_timer_mc

Multi-channel, parametrised successor to the single 64-bit timer. It has a free-running prescaled counter of configurable width and N_CH compare channels. Each channel raises a sticky match flag and a maskable interrupt, in one-shot or periodic mode. It sits on the CPU native slave bus as a peripheral, with one interrupt line per channel to the interrupt controller.

## Interface
- ADDR_W, 6: word address width; must cover 8+4·N_CH words.
- DATA_W, 32: bus data width.
- CNT_W, 64: counter and compare width; DATA_W < CNT_W ≤ 2·DATA_W.
- N_CH, 4: number of compare channels, 1..8.
- PRESC_W, 16: prescaler width.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  request strobe.
- address  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- wstrb  input  DATA_W/8  write strobes; any nonzero value is a full-word write, all zero is a read.
- rdata  output  DATA_W  registered read data; reset 0.
- ready  output  1  registered acknowledge; reset 0.
- irq  output  N_CH  per-channel interrupt, flag[c] & irq_en[c], from flops; reset 0.

## Operation
- Global map (word address):
  - 0 CTRL: bit0 enable (R/W); bit1 soft reset (W, self-clearing); bit2 sample (W, self-clearing).
  - 1 PRESC: tick period minus 1.
  - 2 CNT_LO / 3 CNT_HI: sampled counter, bits above CNT_W read 0.
  - 4 IRQ_STATUS: flag vector, read-only.
  - 5–7 read 0.
- Channel c base 8+4c:
  - +0 CMP_LO: writes a shadow register only.
  - +1 CMP_HI: write commits {wdata, shadow} to cmp atomically.
  - +2 PERIOD: DATA_W, zero-extended.
  - +3 CFG: bit0 ch_en, bit1 periodic, bit2 irq_en, bit8 flag (read; write 1 clears).
- Unmapped addresses read 0; writes to them are ignored.
- Prescaler: pcnt counts 0..PRESC while enable=1; tick when pcnt==PRESC, then pcnt←0. PRESC=0 ticks every cycle. pcnt holds while enable=0.
- Counter: on tick, cnt←cnt+1 mod 2^CNT_W; wraps to 0 silently.
- Soft reset: cnt←0 and pcnt←0. Flags, cmp and config are kept.
- Sample: cnt_reg←cnt at the same edge; reads of CNT_LO/HI return cnt_reg.
- Match for channel c: tick & ch_en & (cnt+1 == cmp). At that edge:
  - flag←1.
  - One-shot: ch_en←0.
  - Periodic: cmp←cmp+PERIOD mod 2^CNT_W, ch_en stays 1.
- Flag set and W1C in the same cycle: set wins.
- Bus write to cmp or CFG in the same cycle as a match: the bus write wins for cmp/ch_en; the flag still sets.
- cmp equal to current cnt does not match until the counter wraps.
- All reset values 0: ctrl, presc, cnt, pcnt, cnt_reg, shadow, cmp, period, cfg, flags.

## Timing
- ready asserts exactly 1 cycle after each valid cycle, for 1 cycle; rdata is valid in the same cycle as ready.
- Back-to-back valid is allowed; each request gets its own ready.
- Register writes take effect at the edge ending the valid cycle.
- Enable written 1 at edge E: with PRESC=P, first increment at edge E+P+1.
- Sample at edge E: a read issued at E (valid in the next cycle) returns the sampled value.
- irq rises 1 cycle after the match edge (flag is a flop; irq is registered from flag & irq_en).
- irq falls 1 cycle after the W1C edge or the irq_en clear.
- rst low at any point: all state clears immediately, including an in-flight ready. First request accepted in the first cycle after rst rises.

## Configuration
- TIMER_MC_PERIODIC_EN defined: periodic bit and PERIOD registers implemented as above.
- Not defined: PERIOD reads 0 and writes are ignored; CFG bit1 reads 0; every channel is one-shot. No adder logic is synthesised.

## Test plan
- Reset, then read every address -> all rdata 0, irq 0. Each read gets ready exactly 1 cycle after valid.
- PRESC=3, enable, wait 40 cycles, sample, read CNT_LO -> 10 (±0 given the fixed enable edge).
- Ch0: CMP={0,5}, ch_en|irq_en, PRESC=0, enable -> flag and irq at cycles 5/6 after enable; ch_en reads 0. W1C flag -> irq 0 next cycle.
- Periodic (macro defined): ch1 CMP=4, PERIOD=4 -> IRQ_STATUS[1] sets at cnt 4, 8, 12; clearing between matches shows three distinct pulses. Macro undefined -> single match only.
- Wrap: CNT_W=64, soft reset, CMP=0, write cnt near wrap via 2^64-3 compare chain (ch2 one-shot CMP=2^64-1 with PRESC=0 via force) -> ch2 matches at all-ones, then ch0 matches at 0.
- Flag W1C in the same cycle as a new match -> flag stays 1. CMP_LO write alone never changes the match point until CMP_HI is written.
